npc_fetch_seq: RTL and testbench
================================

// Module: npc_fetch_seq
// PURPOSE
//  Fetch sequencer on the far side of the PC register: it consumes PC and
//  produces the NPC that the register loads on every clock edge. It issues
//  a req/ack fetch to instruction memory and presents the fetched word to
//  decode. NPC is held at PC until a fetch completes, then advances to
//  PC+4 or to a redirect target. Misaligned PCs and memory timeouts park
//  the core in an error state.
// PARAMETERS
//  TIMEOUT_CYC  255  max REQ cycles without imem_ack before error; range 1..255
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous reset, active-high
//  PC               in   32  current PC from PC register
//  NPC              out  32  next PC; loaded by PC register every clock
//  imem_req         out  1   fetch request to instruction memory
//  imem_addr        out  32  fetch address; always equals PC
//  imem_ack         in   1   fetch done; imem_rdata valid in same cycle
//  imem_rdata       in   32  fetched instruction word
//  instr            out  32  registered instruction for decode
//  instr_valid      out  1   instr valid for decode this cycle
//  stall            in   1   decode/execute hold request
//  redirect         in   1   taken branch/jump/exception
//  redirect_target  in   32  redirect address; bits [1:0] forced to 00
//  fetch_err        out  1   sticky error flag
// BEHAVIOUR
//  FSM states: IDLE, REQ, DONE, ERR. rst is asynchronous and takes effect
//  immediately, including mid-fetch:
//   state=IDLE; instr=0; instr_valid=0; imem_req=0; fetch_err=0;
//   pend=0; pend_tgt=0; tcnt=0.
//  NPC=PC in every state/cycle not listed below as an advance.
//  IDLE: one cycle after reset, then REQ. If PC[1:0]!=0, go to ERR.
//  REQ: imem_req=1 (combinational), imem_addr=PC, tcnt increments each cycle.
//   - redirect=1 without ack: pend<=1, pend_tgt<=redirect_target&~3.
//     A later redirect overwrites pend_tgt.
//   - ack, no pend and no redirect this cycle: instr<=imem_rdata, go to DONE.
//     A zero-wait ack in the first REQ cycle is legal.
//   - ack with pend or redirect this cycle: drop the word. Advance: NPC=target,
//     where a same-cycle redirect beats pend_tgt. pend<=0, tcnt<=0, stay in
//     REQ; the next fetch uses the new PC.
//   - tcnt==TIMEOUT_CYC and no ack: go to ERR.
//  DONE: instr_valid=1.
//   - redirect=1 (overrides stall): advance, NPC=redirect_target&~3, go to REQ.
//   - stall=1, no redirect: stay in DONE; instr and instr_valid held, NPC=PC.
//   - otherwise: advance, NPC=PC+4 mod 2^32 (0xFFFFFFFC->0), go to REQ.
//   - Leaving DONE: tcnt<=0. If the new PC is misaligned, the following
//     REQ->ERR check applies.
//  REQ entry check: if PC[1:0]!=0, go to ERR on that cycle and
//   suppress imem_req.
//  ERR: fetch_err=1, imem_req=0, instr_valid=0, NPC=PC. Only rst exits ERR.
//  Throughput: 2 cycles per instruction minimum (REQ with ack, then DONE).
//  imem_ack outside REQ is ignored.
// TESTING
//  T1 reset, ack every REQ first cycle, no stall -> PC 0,0,4,4,8; instr_valid
//     high every 2nd cycle; imem_addr==PC while req high.
//  T2 ack delayed 3 cycles at PC=0x10 -> NPC=0x10 held for 4 cycles;
//     then DONE; then NPC=0x14.
//  T3 redirect=1, target 0x40, during REQ wait at PC=0x8, ack 2 cycles
//     later -> no instr_valid; ack cycle NPC=0x40; next imem_addr=0x40.
//  T4 DONE with stall=1 for 5 cycles, then redirect target 0x103 ->
//     instr stable 5 cycles; NPC=0x100.
//  T5 TIMEOUT_CYC=4, no ack -> fetch_err=1 after 4 REQ cycles; imem_req=0;
//     PC frozen until rst.
//  T6 PC=0xFFFFFFFC fetch completes -> NPC=0x0. Assert rst mid-REQ ->
//     imem_req drops same cycle; restart from PC=0.

Source files
------------

// File: rtl/npc_fetch_seq.sv
// Fetch sequencer: drives NPC for the external PC register and runs one
// req/ack fetch per instruction, presenting the fetched word to decode.
module npc_fetch_seq #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  output logic [31:0] NPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        fetch_err
);

  // imem handshake: imem_req stays high for the whole REQ wait; the fetch
  // completes in the cycle where imem_req && imem_ack, and imem_rdata is
  // sampled in that same cycle. imem_ack is ignored while imem_req is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state;
  logic        pend;
  logic [31:0] pend_tgt;
  logic [7:0]  tcnt;

  logic        pc_misal;
  logic [31:0] redir_al;
  logic        req_ok;
  logic        ack_drop;
  logic        timeout_hit;

  assign pc_misal  = (PC[1:0] != 2'b00);
  assign redir_al  = {redirect_target[31:2], 2'b00};
  assign req_ok    = (state == REQ) && !pc_misal;
  assign ack_drop  = req_ok && imem_ack && (pend || redirect);

  // tcnt holds the REQ cycles already spent; the current one makes tcnt+1.
  assign timeout_hit = (({1'b0, tcnt} + 9'd1) == 9'(TIMEOUT_CYC));

  assign imem_req  = req_ok;
  assign imem_addr = PC;

  always_comb begin
    NPC = PC;
    if (ack_drop) begin
      NPC = redirect ? redir_al : pend_tgt;
    end else if (state == DONE) begin
      if (redirect) begin
        NPC = redir_al;
      end else if (!stall) begin
        NPC = PC + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      pend        <= 1'b0;
      pend_tgt    <= '0;
      tcnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_misal) begin
            state     <= ERR;
            fetch_err <= 1'b1;
          end else begin
            state <= REQ;
          end
        end

        REQ: begin
          if (pc_misal) begin
            state     <= ERR;
            fetch_err <= 1'b1;
          end else if (imem_ack) begin
            tcnt <= '0;
            if (pend || redirect) begin
              // Word belongs to the abandoned path; refetch at the target.
              pend <= 1'b0;
            end else begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= DONE;
            end
          end else if (timeout_hit) begin
            state     <= ERR;
            fetch_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
            if (redirect) begin
              pend     <= 1'b1;
              pend_tgt <= redir_al;
            end
          end
        end

        DONE: begin
          if (redirect || !stall) begin
            state       <= REQ;
            instr_valid <= 1'b0;
            tcnt        <= '0;
          end
        end

        ERR: begin
          state <= ERR;
        end

        default: begin
          state <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_fetch_seq.sv
// Bench for npc_fetch_seq: models the PC register, drives per-cycle vectors
// and checks NPC/handshake outputs plus fetched words through a queue.
module tb_npc_fetch_seq;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, npc, imem_addr, imem_rdata, instr, redirect_target;
  logic        imem_req, imem_ack, instr_valid, stall, redirect, fetch_err;
  logic        frc_en;
  logic [31:0] frc_val;

  always #5 clk = ~clk;

  // PC register model; frc_en lets the bench plant an arbitrary PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (frc_en) pc <= frc_val;
    else pc <= npc;
  end

  npc_fetch_seq #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .PC(pc), .NPC(npc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .fetch_err(fetch_err)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        st;
    logic        rd;
    logic [31:0] tgt;
    logic        push;
    logic        frc;
    logic [31:0] frc_val;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_req;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic        prev_valid;
  logic [31:0] held;
  logic [31:0] w[10];

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata,
                              input logic st, input logic rd,
                              input logic [31:0] tgt, input logic push,
                              input logic [31:0] e_pc, input logic [31:0] e_npc,
                              input logic e_req, input logic e_valid,
                              input logic e_err);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.st = st; v.rd = rd; v.tgt = tgt;
    v.push = push; v.frc = 1'b0; v.frc_val = '0;
    v.e_pc = e_pc; v.e_npc = e_npc; v.e_req = e_req;
    v.e_valid = e_valid; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_row(input vec_t v, input string tag);
    logic [31:0] e;
    @(negedge clk);
    imem_ack = v.ack; imem_rdata = v.rdata; stall = v.st;
    redirect = v.rd; redirect_target = v.tgt;
    frc_en = v.frc; frc_val = v.frc_val;
    if (v.push) exp_q.push_back(v.rdata);
    #1;
    check({tag, ".pc"}, pc, v.e_pc);
    check({tag, ".npc"}, npc, v.e_npc);
    check({tag, ".req"}, 32'(imem_req), 32'(v.e_req));
    check({tag, ".addr"}, imem_addr, v.e_pc);
    check({tag, ".valid"}, 32'(instr_valid), 32'(v.e_valid));
    check({tag, ".err"}, 32'(fetch_err), 32'(v.e_err));
    if (instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL %s.instr: got %h with no word expected", tag, instr);
      end else begin
        e = exp_q.pop_front();
        held = e;
        check({tag, ".instr"}, instr, e);
      end
    end else if (instr_valid && prev_valid) begin
      check({tag, ".instr_hold"}, instr, held);
    end
    prev_valid = instr_valid;
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; frc_en = 1'b0;
    imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
    #1;
    check({tag, ".req"}, 32'(imem_req), 32'd0);
    check({tag, ".valid"}, 32'(instr_valid), 32'd0);
    check({tag, ".err"}, 32'(fetch_err), 32'd0);
    check({tag, ".npc"}, npc, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    prev_valid = 1'b0;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect = 1'b0; redirect_target = '0; frc_en = 1'b0; frc_val = '0;
    prev_valid = 1'b0; held = '0;
    for (int i = 0; i < 10; i++) w[i] = $urandom();

    // Columns: ack rdata stall redirect target push | pc npc req valid err
    tbl.push_back(mk(1, w[9], 0, 0, 0, 0,   32'h0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(1, w[0], 0, 0, 0, 1,   32'h0, 32'h0, 1, 0, 0));
    tbl.push_back(mk(1, w[9], 0, 0, 0, 0,   32'h0, 32'h4, 0, 1, 0));
    tbl.push_back(mk(1, w[1], 0, 0, 0, 1,   32'h4, 32'h4, 1, 0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0,   32'h4, 32'h8, 0, 1, 0));
    tbl.push_back(mk(0, 0,    0, 1, 32'h40, 0, 32'h8, 32'h8, 1, 0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0,   32'h8, 32'h8, 1, 0, 0));
    tbl.push_back(mk(1, w[9], 0, 0, 0, 0,   32'h8, 32'h40, 1, 0, 0));
    tbl.push_back(mk(1, w[2], 0, 0, 0, 1,   32'h40, 32'h40, 1, 0, 0));
    tbl.push_back(mk(0, 0,    0, 1, 32'h10, 0, 32'h40, 32'h10, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0,  0, 0, 0, 0,   32'h10, 32'h10, 1, 0, 0));
    tbl.push_back(mk(1, w[3], 0, 0, 0, 1,   32'h10, 32'h10, 1, 0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0,   32'h10, 32'h14, 0, 1, 0));
    tbl.push_back(mk(1, w[4], 0, 0, 0, 1,   32'h14, 32'h14, 1, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0,  1, 0, 0, 0,   32'h14, 32'h14, 0, 1, 0));
    tbl.push_back(mk(0, 0,    1, 1, 32'h103, 0, 32'h14, 32'h100, 0, 1, 0));
    tbl.push_back(mk(0, 0,    0, 1, 32'h200, 0, 32'h100, 32'h100, 1, 0, 0));
    tbl.push_back(mk(1, w[9], 0, 1, 32'h300, 0, 32'h100, 32'h300, 1, 0, 0));
    tbl.push_back(mk(0, 0,    0, 1, 32'h500, 0, 32'h300, 32'h300, 1, 0, 0));
    tbl.push_back(mk(0, 0,    0, 1, 32'h602, 0, 32'h300, 32'h300, 1, 0, 0));
    tbl.push_back(mk(1, w[9], 0, 0, 0, 0,   32'h300, 32'h600, 1, 0, 0));
    tbl.push_back(mk(1, w[5], 0, 0, 0, 1,   32'h600, 32'h600, 1, 0, 0));
    tbl.push_back(mk(0, 0,    0, 1, 32'hFFFF_FFFF, 0, 32'h600, 32'hFFFF_FFFC, 0, 1, 0));
    tbl.push_back(mk(1, w[6], 0, 0, 0, 1,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0,   32'hFFFF_FFFC, 32'h0, 0, 1, 0));
    tbl.push_back(mk(1, w[7], 0, 0, 0, 1,   32'h0, 32'h0, 1, 0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0,   32'h0, 32'h4, 0, 1, 0));

    pulse_reset("rst0");
    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], $sformatf("row%0d", i));

    // Reset in the middle of a REQ wait drops imem_req immediately.
    run_row(mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h4, 1, 0, 0), "midreq");
    pulse_reset("rst_midreq");
    run_row(mk(0, 0,    0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0), "re_idle");
    run_row(mk(1, w[8], 0, 0, 0, 1, 32'h0, 32'h0, 1, 0, 0), "re_req");
    run_row(mk(0, 0,    0, 0, 0, 0, 32'h0, 32'h4, 0, 1, 0), "re_done");

    // Timeout: TO REQ cycles without ack, then a sticky error.
    for (int i = 0; i < int'(TO); i++)
      run_row(mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h4, 1, 0, 0), $sformatf("to_req%0d", i));
    run_row(mk(1, w[9], 0, 1, 32'h80, 0, 32'h4, 32'h4, 0, 0, 1), "to_err0");
    run_row(mk(1, w[9], 0, 0, 0, 0,       32'h4, 32'h4, 0, 0, 1), "to_err1");
    run_row(mk(0, 0,    1, 1, 32'h90, 0,  32'h4, 32'h4, 0, 0, 1), "to_err2");

    // Misaligned PC planted after IDLE: REQ must not request, then error.
    pulse_reset("rst_err");
    v = mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    v.frc = 1'b1; v.frc_val = 32'h6;
    run_row(v, "mis_idle");
    run_row(mk(1, w[9], 0, 0, 0, 0, 32'h6, 32'h6, 0, 0, 0), "mis_req");
    run_row(mk(0, 0,    0, 0, 0, 0, 32'h6, 32'h6, 0, 0, 1), "mis_err");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
